// File: rtl/right_shift_iterative_pkg.sv
// Shared constants and state encoding for the iterative right shifter.
// Imported by the top level and by the single combinational stage.
package right_shift_iterative_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned SHAMT_W      = 5;
  localparam int unsigned SHIFT_STAGES = 5;
  localparam int unsigned IDX_W        = 3;

  // The first stage applied is the widest one (16 bits).
  localparam logic [IDX_W-1:0] IDX_START = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Sign (or zero) bit replicated into vacated positions.
  function automatic logic fill_bit(input logic msb, input logic arith);
    return msb & arith;
  endfunction

endpackage

// File: rtl/right_shift_iterative_stage.sv
// One binary-weighted right-shift stage, fill-extended.
// The stage index selects a shift distance of 2^idx.
module right_shift_stage
  import right_shift_iterative_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              fill_i,
  output logic [DATA_W-1:0] data_o
);

  // Distance decode: out-of-range indices pass the data through untouched.
  always_comb begin
    data_o = data_i;
    case (idx_i)
      3'd0:    data_o = {fill_i, data_i[DATA_W-1:1]};
      3'd1:    data_o = {{2{fill_i}}, data_i[DATA_W-1:2]};
      3'd2:    data_o = {{4{fill_i}}, data_i[DATA_W-1:4]};
      3'd3:    data_o = {{8{fill_i}}, data_i[DATA_W-1:8]};
      3'd4:    data_o = {{16{fill_i}}, data_i[DATA_W-1:16]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/right_shift_iterative.sv
// Multi-cycle 32-bit logical/arithmetic right shifter, one stage per cycle.
// Fixed five-cycle latency from the accepted start to the done pulse.
module right_shift_iterative
  import right_shift_iterative_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               sra,
  output logic [DATA_W-1:0]  result,
  output logic               ready,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic               fill_q, fill_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  stage_out_s;

  right_shift_stage u_stage (
    .data_i (data_q),
    .idx_i  (idx_q),
    .fill_i (fill_q),
    .data_o (stage_out_s)
  );

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= {DATA_W{1'b0}};
      amt_q   <= {SHAMT_W{1'b0}};
      fill_q  <= 1'b0;
      idx_q   <= IDX_START;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; a stage only modifies data when its amount bit is set.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          data_d  = in;
          amt_d   = shamt;
          fill_d  = fill_bit(in[DATA_W-1], sra);
          idx_d   = IDX_START;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (amt_q[idx_q]) begin
          data_d = stage_out_s;
        end else begin
          data_d = data_q;
        end
        if (idx_q == 3'd0) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags decode straight from the state register; start never reaches them.
  assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign result = data_q;

endmodule

// File: doc/right_shift_iterative.md
# right_shift_iterative

Multi-cycle 32-bit right shifter for the CPU execute stage. It performs both logical (sra = 0) and arithmetic (sra = 1) right shifts. It applies one binary-weighted stage per cycle (16, 8, 4, 2, 1) under a start/done handshake, which removes the five-level barrel from the single-cycle ALU path. It is the right-shift counterpart of the combinational left-shift stages, and the stall logic holds the pipeline while busy is high.

## Interface
- Parameters: none. Datapath is fixed at 32 bits; shift amount is fixed at 5 bits.
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; forces the idle state immediately
- start  input  1  request; sampled on a rising edge only when ready = 1
- in  input  32  operand; captured with start
- shamt  input  5  shift amount 0..31; captured with start
- sra  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured with start
- result  output  32  shifted value; valid while done = 1, held until the next accepted start
- ready  output  1  1 in IDLE and DONE; a start is accepted only in these states
- busy  output  1  1 in SHIFT
- done  output  1  one-cycle pulse: result is final

## Operation
- States: IDLE, SHIFT, DONE.
- Registers:
  - state
  - data[31:0]
  - amt[4:0]
  - fill (captured value of in[31] & sra)
  - idx[2:0] (stage index, 4 down to 0)
- IDLE or DONE with start = 1:
  - data <= in, amt <= shamt, fill <= in[31] & sra, idx <= 4
  - state -> SHIFT
- IDLE with start = 0: hold state and all registers.
- SHIFT, each edge:
  - if amt[idx] = 1, data <= data shifted right by 2^idx, with the vacated upper 2^idx bits set to fill; otherwise data is unchanged.
  - If idx = 0, state -> DONE; otherwise idx <= idx - 1.
- DONE with start = 0: state -> IDLE, data held.
- start is ignored while in SHIFT; no queuing, no error flag.
- result = data at all times.
  - Consumers use it only when done = 1, or any time after that until the next accepted start.
- Fill bit: always the captured sign, never the current data[31].
- shamt = 0 still traverses all five stages; the result equals the operand.
- shamt = 31, logical: result is in[31] in bit 0, zeros above.
- shamt = 31, arithmetic: result is 32 copies of in[31].

## Timing
- Reset values:
  - state = IDLE, data = 0, amt = 0, fill = 0, idx = 4
  - result = 0x00000000, ready = 1, busy = 0, done = 0
- Fixed latency regardless of shamt:
  - start sampled at edge N
  - stages applied at edges N+1 .. N+5
  - done = 1 from edge N+5 to edge N+6
- Throughput with back-to-back requests:
  - a start held high during the DONE cycle is accepted at edge N+6
  - done pulses every 6 cycles
- busy = 1 from edge N+1 through edge N+5, and 0 during DONE.
- Output derivation:
  - ready, busy and done decode directly from the state register, with no combinational path from start.
  - result is a direct register output.
- Reset asserted mid-operation:
  - outputs return to their reset values asynchronously
  - the in-flight shift is discarded and no done pulse is produced
  - the first start after reset release is accepted normally

## Structure
- Shared CPU package holds:
  - state encoding (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2)
  - SHIFT_STAGES = 5 and the width constant 32
- Sub-module right_shift_stage, purely combinational:
  - inputs: data[31:0], idx[2:0], fill
  - output: data shifted right by 2^idx, fill-extended
  - it is selected by idx inside the block and instantiated once.
- Top level contains the FSM, the capture registers and the stage-enable gating by amt[idx].

## Test plan
- Logical shift: in = 0x80000000, shamt = 31, sra = 0 -> result 0x00000001, done exactly 5 cycles after the start edge.
- Arithmetic shift: in = 0x80000000, shamt = 4, sra = 1 -> 0xF8000000. Same operand with sra = 0 -> 0x08000000. Also in = 0x7FFF0000, shamt = 16, sra = 1 -> 0x00007FFF.
- Zero shift: in = 0xDEADBEEF, shamt = 0 -> 0xDEADBEEF, still 5-cycle latency, busy high for exactly 5 cycles.
- Start while busy: pulse start with a new operand at edges N+2 and N+4 -> ignored. The first result is unchanged, and a single done pulse follows.
- Back-to-back requests:
  - first: in = 0x12345678, shamt = 8 -> 0x00123456
  - second, start held in the DONE cycle: in = 0xF0000000, shamt = 28, sra = 1 -> 0xFFFFFFFF
  - done pulses 6 cycles apart.
- Reset mid-operation: assert reset between the edges at N+3 and N+4 -> immediately state = IDLE, result = 0, busy = 0, ready = 1, no done pulse. After release, a fresh start completes correctly.
